// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped write-back cache and its backing
// memory: default geometry, derived address-field widths and the controller
// state encoding.
package cache_pkg;
   localparam int PA_WIDTH   = 32;   // physical byte-address width
   localparam int WRD_WIDTH  = 32;   // CPU word width
   localparam int BLK_WIDTH  = 512;  // cache block width (64 bytes)
   localparam int BYTE       = 8;
   localparam int NUM_LINES  = 16;   // direct-mapped lines
   localparam int MEM_DEPTH  = 256;  // backing memory blocks

   localparam int OFFSET_W   = 6;    // byte offset within a block
   localparam int WORD_SEL_W = 4;    // word select within a block
   localparam int BYTE_SEL_W = 2;    // byte select within a word
   localparam int INDEX_W    = 4;    // line index
   localparam int TAG_W      = PA_WIDTH - OFFSET_W - INDEX_W;

   typedef enum logic [2:0] {
      IDLE,
      COMPARE,
      WRITEBACK,
      ALLOCATE,
      FILL
   } cache_state_t;
endpackage

// File: rtl/cache_data_mem_mem.sv
// Backing block memory for the cache.
//   clk               rising-edge clock
//   wr_en/rd_en       controller write / read strobes
//   addr              controller byte address (block index taken from it)
//   wr_data/rd_data   block write data / registered block read data
//   bd_wr_en          backdoor preload strobe (already gated by the caller)
//   bd_addr/bd_blk    backdoor byte address and block
// Writes are synchronous; read data appears the cycle after rd_en.
// The array is never reset.
module cache_data_mem_mem #(
   parameter int PA_WIDTH  = cache_pkg::PA_WIDTH,
   parameter int BLK_WIDTH = cache_pkg::BLK_WIDTH,
   parameter int MEM_DEPTH = cache_pkg::MEM_DEPTH
) (
   input  logic                 clk,
   input  logic                 wr_en,
   input  logic                 rd_en,
   input  logic [PA_WIDTH-1:0]  addr,
   input  logic [BLK_WIDTH-1:0] wr_data,
   output logic [BLK_WIDTH-1:0] rd_data,
   input  logic                 bd_wr_en,
   input  logic [PA_WIDTH-1:0]  bd_addr,
   input  logic [BLK_WIDTH-1:0] bd_blk
);
   import cache_pkg::*;

   localparam int OFS_BITS  = $clog2(BLK_WIDTH / BYTE);
   localparam int MIDX_BITS = $clog2(MEM_DEPTH);

   logic [BLK_WIDTH-1:0] mem_array [MEM_DEPTH];
   logic [MIDX_BITS-1:0] idx;
   logic [MIDX_BITS-1:0] bd_idx;
   logic                 unused_addr_bits;

   assign idx    = addr[OFS_BITS +: MIDX_BITS];
   assign bd_idx = bd_addr[OFS_BITS +: MIDX_BITS];

   // Offset and high address bits do not select a memory block.
   assign unused_addr_bits = ^{addr[PA_WIDTH-1:OFS_BITS+MIDX_BITS], addr[OFS_BITS-1:0],
                               bd_addr[PA_WIDTH-1:OFS_BITS+MIDX_BITS], bd_addr[OFS_BITS-1:0]};

   // Controller write takes priority over a coincident backdoor write.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem_array[idx] <= wr_data;
      else if (bd_wr_en)
         mem_array[bd_idx] <= bd_blk;
      if (rd_en)
         rd_data <= mem_array[idx];
   end
endmodule

// File: rtl/cache_data_mem.sv
// Direct-mapped, write-back / write-allocate data cache with its backing
// memory.
//   clk                rising-edge clock
//   rst_n              asynchronous reset, ACTIVE-HIGH despite its name
//   rd_en/wr_en        CPU read / write request (write wins when both set)
//   addr, data_wr      CPU byte address and write word
//   bd_wr_en/bd_addr/bd_blk  backdoor memory preload (honoured only in IDLE)
//   hit                last completed request hit on its first lookup
//   ready              one-cycle completion pulse
//   word_out/byte_out  addressed word / byte of the last completed request
module cache_data_mem #(
   parameter int PA_WIDTH  = cache_pkg::PA_WIDTH,
   parameter int WRD_WIDTH = cache_pkg::WRD_WIDTH,
   parameter int BLK_WIDTH = cache_pkg::BLK_WIDTH,
   parameter int NUM_LINES = cache_pkg::NUM_LINES,
   parameter int MEM_DEPTH = cache_pkg::MEM_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rd_en,
   input  logic                 wr_en,
   input  logic [PA_WIDTH-1:0]  addr,
   input  logic [WRD_WIDTH-1:0] data_wr,
   input  logic                 bd_wr_en,
   input  logic [PA_WIDTH-1:0]  bd_addr,
   input  logic [BLK_WIDTH-1:0] bd_blk,
   output logic                 hit,
   output logic                 ready,
   output logic [WRD_WIDTH-1:0] word_out,
   output logic [7:0]           byte_out
);
   import cache_pkg::*;

   localparam int OFS_BITS  = $clog2(BLK_WIDTH / BYTE);
   localparam int IDX_BITS  = $clog2(NUM_LINES);
   localparam int TAG_BITS  = PA_WIDTH - OFS_BITS - IDX_BITS;
   localparam int WSEL_BITS = $clog2(BLK_WIDTH / WRD_WIDTH);
   localparam int BSEL_BITS = $clog2(WRD_WIDTH / BYTE);

   cache_state_t         state;
   logic [NUM_LINES-1:0] line_valid;
   logic [NUM_LINES-1:0] line_dirty;
   logic [TAG_BITS-1:0]  line_tag  [NUM_LINES];
   logic [BLK_WIDTH-1:0] line_data [NUM_LINES];

   logic [PA_WIDTH-1:0]  req_addr;
   logic [WRD_WIDTH-1:0] req_data;
   logic                 req_wr;
   logic                 first_lookup;

   logic                 mem_wr_en;
   logic                 mem_rd_en;
   logic [PA_WIDTH-1:0]  mem_addr;
   logic [BLK_WIDTH-1:0] mem_wr_data;
   logic [BLK_WIDTH-1:0] mem_rd_data;

   logic [IDX_BITS-1:0]  req_idx;
   logic [TAG_BITS-1:0]  req_tag;
   logic [WSEL_BITS-1:0] req_wsel;
   logic [BSEL_BITS-1:0] req_bsel;
   logic                 lookup_hit;
   logic                 need_wb;
   logic [WRD_WIDTH-1:0] cur_word;
   logic [WRD_WIDTH-1:0] out_word;
   logic [BYTE-1:0]      out_byte;
   logic [PA_WIDTH-1:0]  fill_addr;
   logic [PA_WIDTH-1:0]  victim_addr;

   assign req_idx     = req_addr[OFS_BITS +: IDX_BITS];
   assign req_tag     = req_addr[PA_WIDTH-1 -: TAG_BITS];
   assign req_wsel    = req_addr[BSEL_BITS +: WSEL_BITS];
   assign req_bsel    = req_addr[0 +: BSEL_BITS];
   assign lookup_hit  = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
   assign need_wb     = line_valid[req_idx] && line_dirty[req_idx];
   assign cur_word    = line_data[req_idx][req_wsel*WRD_WIDTH +: WRD_WIDTH];
   // A write hit replaces the whole addressed word, so the merged word is data_wr.
   assign out_word    = req_wr ? req_data : cur_word;
   assign out_byte    = out_word[req_bsel*BYTE +: BYTE];
   assign fill_addr   = {req_tag, req_idx, {OFS_BITS{1'b0}}};
   assign victim_addr = {line_tag[req_idx], req_idx, {OFS_BITS{1'b0}}};

   // Controller state, line status bits and outputs. Memory strobes are
   // registered one state ahead so they are live during WRITEBACK/ALLOCATE,
   // and an asynchronous reset drops them before the next edge.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state        <= IDLE;
         line_valid   <= '0;
         line_dirty   <= '0;
         req_wr       <= 1'b0;
         first_lookup <= 1'b0;
         hit          <= 1'b0;
         ready        <= 1'b0;
         word_out     <= '0;
         byte_out     <= '0;
         mem_wr_en    <= 1'b0;
         mem_rd_en    <= 1'b0;
      end else begin
         ready     <= 1'b0;
         mem_wr_en <= 1'b0;
         mem_rd_en <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_en || wr_en) begin
                  req_wr       <= wr_en;
                  first_lookup <= 1'b1;
                  state        <= COMPARE;
               end
            end
            COMPARE: begin
               if (lookup_hit) begin
                  if (req_wr)
                     line_dirty[req_idx] <= 1'b1;
                  word_out <= out_word;
                  byte_out <= out_byte;
                  hit      <= first_lookup;
                  ready    <= 1'b1;
                  state    <= IDLE;
               end else begin
                  first_lookup <= 1'b0;
                  if (need_wb) begin
                     mem_wr_en <= 1'b1;
                     state     <= WRITEBACK;
                  end else begin
                     mem_rd_en <= 1'b1;
                     state     <= ALLOCATE;
                  end
               end
            end
            WRITEBACK: begin
               mem_rd_en <= 1'b1;
               state     <= ALLOCATE;
            end
            ALLOCATE: begin
               state <= FILL;
            end
            FILL: begin
               line_valid[req_idx] <= 1'b1;
               line_dirty[req_idx] <= 1'b0;
               state               <= COMPARE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Request capture, line contents and memory address/data (no reset).
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (rd_en || wr_en) begin
               req_addr <= addr;
               req_data <= data_wr;
            end
         end
         COMPARE: begin
            if (lookup_hit) begin
               if (req_wr)
                  line_data[req_idx][req_wsel*WRD_WIDTH +: WRD_WIDTH] <= req_data;
            end else if (need_wb) begin
               mem_addr    <= victim_addr;
               mem_wr_data <= line_data[req_idx];
            end else begin
               mem_addr <= fill_addr;
            end
         end
         WRITEBACK: mem_addr <= fill_addr;
         FILL: begin
            line_data[req_idx] <= mem_rd_data;
            line_tag[req_idx]  <= req_tag;
         end
         default: ;
      endcase
   end

   cache_data_mem_mem #(
      .PA_WIDTH  (PA_WIDTH),
      .BLK_WIDTH (BLK_WIDTH),
      .MEM_DEPTH (MEM_DEPTH)
   ) u_mem (
      .clk      (clk),
      .wr_en    (mem_wr_en),
      .rd_en    (mem_rd_en),
      .addr     (mem_addr),
      .wr_data  (mem_wr_data),
      .rd_data  (mem_rd_data),
      .bd_wr_en (bd_wr_en && (state == IDLE)),
      .bd_addr  (bd_addr),
      .bd_blk   (bd_blk)
   );
endmodule

// File: tb/tb_cache_data_mem.sv
module tb_cache_data_mem;
   localparam int NL = 16;
   localparam int MD = 256;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         rd_en, wr_en, bd_wr_en;
   logic [31:0]  addr, data_wr, bd_addr;
   logic [511:0] bd_blk;
   logic         hit, ready;
   logic [31:0]  word_out;
   logic [7:0]   byte_out;

   always #5 clk = ~clk;

   cache_data_mem dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_en    (rd_en),
      .wr_en    (wr_en),
      .addr     (addr),
      .data_wr  (data_wr),
      .bd_wr_en (bd_wr_en),
      .bd_addr  (bd_addr),
      .bd_blk   (bd_blk),
      .hit      (hit),
      .ready    (ready),
      .word_out (word_out),
      .byte_out (byte_out)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference: "truth" is what the CPU should observe for every block,
   // "backing" is what the memory should hold; they differ only for blocks
   // resident and dirty in the cache.
   logic [511:0] truth   [MD];
   logic [511:0] backing [MD];
   bit           m_valid [NL];
   bit           m_dirty [NL];
   int           m_tag   [NL];

   task automatic check(input string tag, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic preload(input int blk, input logic [511:0] val);
      @(negedge clk);
      bd_wr_en = 1'b1;
      bd_addr  = 32'(blk) << 6;
      bd_blk   = val;
      @(negedge clk);
      bd_wr_en = 1'b0;
      truth[blk]   = val;
      backing[blk] = val;
   endtask

   task automatic model_reset();
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      for (int i = 0; i < MD; i++) truth[i] = backing[i];
   endtask

   task automatic request(input bit do_rd, input bit do_wr, input logic [31:0] a,
                          input logic [31:0] d, input bit poke_busy);
      int blk, idx, t, w, b, exp_lat, lat, victim;
      bit exp_hit;
      logic [31:0] exp_word;
      blk = int'(a[13:6]);
      idx = blk % NL;
      t   = blk / NL;
      w   = int'(a[5:2]);
      b   = int'(a[1:0]);
      victim  = -1;
      exp_hit = m_valid[idx] && (m_tag[idx] == t);
      if (exp_hit) exp_lat = 1;
      else begin
         if (m_valid[idx] && m_dirty[idx]) begin
            victim = m_tag[idx] * NL + idx;
            backing[victim] = truth[victim];
            exp_lat = 5;
         end else exp_lat = 4;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = t;
         m_dirty[idx] = 1'b0;
      end
      if (do_wr) begin
         truth[blk][w*32 +: 32] = d;
         m_dirty[idx] = 1'b1;
      end
      exp_word = truth[blk][w*32 +: 32];

      @(negedge clk);
      rd_en = do_rd; wr_en = do_wr; addr = a; data_wr = d;
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
      if (poke_busy) begin
         // A request raised while busy must be ignored.
         wr_en = 1'b1; addr = a ^ 32'h400; data_wr = ~d;
      end
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         rd_en = 1'b0; wr_en = 1'b0;
      end while (!ready && lat < 12);
      check("latency", 512'(lat), 512'(exp_lat));
      check("hit", 512'(hit), 512'(exp_hit));
      check("word_out", 512'(word_out), 512'(exp_word));
      check("byte_out", 512'(byte_out), 512'(exp_word[b*8 +: 8]));
      if (victim >= 0) check("wb_block", dut.u_mem.mem_array[victim], backing[victim]);
      @(posedge clk); #1;
      check("ready_pulse", 512'(ready), 512'(0));
   endtask

   // Start a read miss at a, then assert reset once the controller has left
   // COMPARE (WRITEBACK for a dirty victim, ALLOCATE for a clean one).
   task automatic reset_during(input logic [31:0] a);
      int blk, idx, victim;
      blk = int'(a[13:6]);
      idx = blk % NL;
      victim = (m_valid[idx] && m_dirty[idx]) ? m_tag[idx] * NL + idx : blk;
      @(negedge clk);
      rd_en = 1'b1; addr = a;
      @(posedge clk); #1;
      rd_en = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("rst_hit", 512'(hit), 512'(0));
      check("rst_ready", 512'(ready), 512'(0));
      check("rst_word", 512'(word_out), 512'(0));
      check("rst_byte", 512'(byte_out), 512'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_no_wb", dut.u_mem.mem_array[victim], backing[victim]);
      model_reset();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [511:0] v;
      rst_n = 1'b1; rd_en = 1'b0; wr_en = 1'b0; bd_wr_en = 1'b0;
      addr = '0; data_wr = '0; bd_addr = '0; bd_blk = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_hit", 512'(hit), 512'(0));
      check("reset_ready", 512'(ready), 512'(0));
      check("reset_word", 512'(word_out), 512'(0));
      check("reset_byte", 512'(byte_out), 512'(0));
      @(negedge clk);
      rst_n = 1'b0;

      for (int blk = 0; blk < MD; blk++) begin
         for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
         preload(blk, v);
      end
      preload(0, {16{32'hFFFFFFFF}});
      preload(1, {16{32'hAAAAAAAA}});

      // Directed scenario
      request(1, 0, 32'h000, 32'h0, 0);
      check("d_miss_word", 512'(word_out), 512'(32'hFFFFFFFF));
      check("d_miss_byte", 512'(byte_out), 512'(8'hFF));
      request(1, 0, 32'h004, 32'h0, 0);
      check("d_hit_flag", 512'(hit), 512'(1));
      request(0, 1, 32'h044, 32'h12345678, 1);
      request(1, 0, 32'h045, 32'h0, 0);
      check("d_byte56", 512'(byte_out), 512'(8'h56));
      request(1, 0, 32'h440, 32'h0, 0);
      v = dut.u_mem.mem_array[1];
      check("d_wb_word1", 512'(v[63:32]), 512'(32'h12345678));
      check("d_wb_word0", 512'(v[31:0]), 512'(32'hAAAAAAAA));
      check("d_wb_word15", 512'(v[511:480]), 512'(32'hAAAAAAAA));
      request(1, 1, 32'h008, 32'hDEADBEEF, 0);
      check("d_both_word", 512'(word_out), 512'(32'hDEADBEEF));

      // Randomized traffic over four tags so lines conflict often
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         int op;
         a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 6)
              | 32'($urandom_range(0, 63));
         op = $urandom_range(0, 2);
         request(op != 1, op != 0, a, $urandom, ($urandom_range(0, 3) == 0));
      end

      // Reset during WRITEBACK of a dirty victim
      request(0, 1, 32'h080, 32'hCAFEF00D, 0);
      reset_during(32'h480);
      request(1, 0, 32'h080, 32'h0, 0);
      check("post_rst_miss", 512'(hit), 512'(0));

      // Reset during ALLOCATE of a clean miss
      request(1, 0, 32'h0C0, 32'h0, 0);
      request(1, 0, 32'h0C4, 32'h0, 0);
      reset_during(32'h4C0);
      request(1, 0, 32'h0C4, 32'h0, 0);
      check("post_rst_miss2", 512'(hit), 512'(0));

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/cache_data_mem.md
CACHE_DATA_MEM -- requirements
Module: cache_data_mem

Interface
REQ-001 Parameter PA_WIDTH, default 32, physical byte-address width.
REQ-002 Parameter WRD_WIDTH, default 32, CPU word width.
REQ-003 Parameter BLK_WIDTH, default 512, cache block width (64 bytes, 16 words).
REQ-004 Parameter NUM_LINES, default 16, direct-mapped line count; MEM_DEPTH, default 256, memory blocks.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous reset, active-high despite the suffix.
REQ-008 rd_en  in  1  CPU read request.
REQ-009 wr_en  in  1  CPU write request.
REQ-010 addr  in  PA_WIDTH  CPU byte address.
REQ-011 data_wr  in  WRD_WIDTH  CPU write word.
REQ-012 bd_wr_en  in  1  backdoor memory preload strobe.
REQ-013 bd_addr  in  PA_WIDTH  backdoor block address.
REQ-014 bd_blk  in  BLK_WIDTH  backdoor preload block.
REQ-015 hit  out  1  last completed request hit on first lookup.
REQ-016 ready  out  1  one-cycle pulse: request complete.
REQ-017 word_out  out  WRD_WIDTH  addressed word after completion.
REQ-018 byte_out  out  8  addressed byte after completion.

Function
REQ-019 Address split: offset addr[5:0] (word addr[5:2], byte addr[1:0]), index addr[9:6], tag addr[31:10]; bytes little-endian within word, words ascending within block.
REQ-020 Line storage: valid, dirty, tag, 512-bit data per line; write-back, write-allocate policy.
REQ-021 FSM states IDLE, COMPARE, WRITEBACK, ALLOCATE, FILL.
REQ-022 IDLE: rd_en or wr_en registers addr, data_wr and op (wr_en wins if both) -> COMPARE; requests outside IDLE ignored.
REQ-023 COMPARE hit: read returns word/byte; write merges data_wr into addressed word and sets dirty; ready=1 one cycle, -> IDLE.
REQ-024 COMPARE miss: dirty victim -> WRITEBACK, else -> ALLOCATE.
REQ-025 WRITEBACK: one cycle, mem write of victim block to address {victim tag, index, 6'b0}, -> ALLOCATE.
REQ-026 ALLOCATE: one cycle, mem read of {tag, index, 6'b0}, -> FILL.
REQ-027 FILL: load mem read data into line, valid=1, dirty=0, tag updated, -> COMPARE (guaranteed hit).
REQ-028 Latency from accepting edge to ready: hit 1 cycle; clean miss 4; dirty miss 5.
REQ-029 hit registered at completion: 1 only if first COMPARE hit; word_out, byte_out, hit hold until next completion.
REQ-030 Write completion: word_out = merged word.
REQ-031 Memory (sub-module mem): MEM_DEPTH x BLK_WIDTH array, indexed addr[13:6]; synchronous write; registered read, data valid the cycle after rd_en.
REQ-032 Backdoor: bd_wr_en writes bd_blk to mem entry bd_addr[13:6]; permitted only in IDLE; controller write has priority on same cycle.

Reset
REQ-033 Reset clears all valid and dirty bits, FSM -> IDLE; hit, ready, word_out, byte_out = 0; mem enables 0.
REQ-034 Reset mid-operation aborts the request; no mem write issued afterward; memory array contents not reset.

Structure
REQ-035 Shared package cache_pkg: PA_WIDTH, WRD_WIDTH, BLK_WIDTH, BYTE=8, offset/index/tag widths, FSM state enum.
REQ-036 Top cache_data_mem contains controller/line storage plus one sub-module instance: mem.

Verification
REQ-037 Preload 0x000 all-F, 0x040 all-A; read 0x000 -> ready after 4 cycles, hit=0, word_out=FFFFFFFF, byte_out=FF.
REQ-038 Then read 0x004 -> ready after 1 cycle, hit=1, word_out=FFFFFFFF.
REQ-039 Write 0x12345678 to 0x044 -> miss, allocate, hit=0; read 0x045 -> hit=1, byte_out=56, word_out=12345678.
REQ-040 Read 0x440 (index 1 conflict) -> dirty miss, 5 cycles, mem block 0x040 word 1 = 12345678, others AAAAAAAA.
REQ-041 rd_en and wr_en together at 0x008 with data 0xDEADBEEF -> treated as write, word_out=DEADBEEF.
REQ-042 Reset asserted in WRITEBACK/ALLOCATE -> outputs 0, no further mem write, next read of a prior hit address misses.
